// File: rtl/param_sync_memory_pkg.sv
// Shared types, init-pattern selectors and the pattern generator for
// param_sync_memory.
package param_sync_memory_pkg;

   typedef enum logic {ST_INIT, ST_RUN} mem_state_e;

   localparam int INIT_ZERO   = 0;
   localparam int INIT_SQUARE = 1;
   localparam int INIT_IDENT  = 2;

   // The result is wide so that the caller can truncate it to its own DW.
   // For i < 2**AW the square fits in 2*AW bits, so the low DW bits match
   // a 2*AW-bit product truncated to DW.
   function automatic logic [63:0] init_pattern(input logic [31:0] i, input int mode);
      logic [63:0] ii;
      ii = {32'b0, i};
      case (mode)
         INIT_SQUARE: init_pattern = ii * ii;
         INIT_IDENT:  init_pattern = ii;
         default:     init_pattern = '0;
      endcase
   endfunction

endpackage

// File: rtl/param_sync_memory_if.sv
// Request/response bus: the master issues requests and consumes responses,
// and the slave (the memory) accepts requests and produces read responses.
interface param_sync_memory_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/param_sync_memory_mem_array.sv
// DW x DEPTH storage with one synchronous write port and one registered read
// port. The read register updates only on re_i, so it holds across stalls.
module param_sync_memory_mem_array #(
   parameter int DW    = 8,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // The top level guarantees that addresses are below DEPTH whenever an
   // enable is active.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/param_sync_memory.sv
// Single-port synchronous memory with a valid/ready request channel, a
// registered read response and a post-reset init engine that fills the array.
module param_sync_memory
   import param_sync_memory_pkg::*;
#(
   parameter int DW        = 8,
   parameter int DEPTH     = 256,
   parameter int AW        = $clog2(DEPTH),
   parameter int INIT_MODE = INIT_SQUARE
) (
   input  logic                  clk,
   input  logic                  rst,
   param_sync_memory_if.slave    bus,
   output logic                  init_done
);
   mem_state_e    state_q;
   logic [AW-1:0] init_cnt_q;
   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic          rd_ok_q;
   logic          init_done_q;

   logic          req_ready;
   logic          in_range;
   logic          rd_acc;
   logic          wr_acc;
   logic          mem_we;
   logic          mem_re;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always_comb begin
      req_ready = (state_q == ST_RUN) && (!rsp_valid_q || bus.rsp_ready);
      in_range  = 32'(bus.req_addr) < DEPTH;
      rd_acc    = bus.req_valid && req_ready && !bus.req_write;
      wr_acc    = bus.req_valid && req_ready && bus.req_write;
   end

   // The init engine owns the write port until RUN; requests are not
   // accepted in INIT, so the two sources never collide.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.req_addr;
      mem_wdata = bus.req_wdata;
      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_waddr = init_cnt_q;
         mem_wdata = DW'(init_pattern(32'(init_cnt_q), INIT_MODE));
      end else if (wr_acc && in_range) begin
         mem_we = 1'b1;
      end
      mem_re = rd_acc && in_range;
   end

   param_sync_memory_mem_array #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem_array (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .re_i    (mem_re),
      .raddr_i (bus.req_addr),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + AW'(1);
               if (init_cnt_q == AW'(DEPTH - 1)) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end
            end
            ST_RUN: begin
               // A new read replaces a response being consumed this cycle,
               // which gives one read per cycle back to back.
               if (rd_acc) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= !in_range;
                  rd_ok_q     <= in_range;
               end else if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   // rd_ok_q masks the uninitialised read register after reset and forces
   // zero data for out-of-range reads.
   assign bus.rsp_rdata = rd_ok_q ? mem_rdata : '0;
   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign init_done     = init_done_q;
endmodule

// File: tb/tb_param_sync_memory.sv
// Scoreboard bench for param_sync_memory: one DEPTH=256 instance and one
// DEPTH=200 instance, both in square-pattern init mode, sharing a muxed stimulus driver.
module tb_param_sync_memory;
   import param_sync_memory_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic init_done0, init_done1;
   bit   sel;

   logic       m_valid, m_write, m_rsp_ready;
   logic [7:0] m_addr, m_wdata;
   logic       o_req_ready, o_rsp_valid, o_rsp_err;
   logic [7:0] o_rsp_rdata;

   logic [7:0] model [2][256];
   int         depth_of [2] = '{256, 200};
   exp_t       sb [$];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   param_sync_memory_if #(.DW(8), .AW(8)) bus0 ();
   param_sync_memory_if #(.DW(8), .AW(8)) bus1 ();

   param_sync_memory #(.DW(8), .DEPTH(256), .INIT_MODE(INIT_SQUARE)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .init_done(init_done0));
   param_sync_memory #(.DW(8), .DEPTH(200), .INIT_MODE(INIT_SQUARE)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .init_done(init_done1));

   assign bus0.req_valid = m_valid && !sel;
   assign bus1.req_valid = m_valid && sel;
   assign bus0.req_write = m_write;
   assign bus1.req_write = m_write;
   assign bus0.req_addr  = m_addr;
   assign bus1.req_addr  = m_addr;
   assign bus0.req_wdata = m_wdata;
   assign bus1.req_wdata = m_wdata;
   assign bus0.rsp_ready = sel ? 1'b1 : m_rsp_ready;
   assign bus1.rsp_ready = sel ? m_rsp_ready : 1'b1;
   assign o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
   assign o_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
   assign o_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
   assign o_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic init_model();
      for (int i = 0; i < 256; i++) begin
         model[0][i] = 8'((i * i) % 256);
         model[1][i] = (i < 200) ? 8'((i * i) % 256) : 8'h00;
      end
   endtask

   // Scoreboard: retire the response consumed at the coming edge first, then
   // record the request accepted at that same edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (o_rsp_valid && m_rsp_ready) begin
            chk("sb_nonempty", sb.size(), 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               $display("rsp dut%0d addr=%0d data=%02h err=%0b", sel, e.addr, o_rsp_rdata, o_rsp_err);
               chk($sformatf("rsp_data[%0d]", e.addr), o_rsp_rdata, e.data);
               chk($sformatf("rsp_err[%0d]", e.addr), o_rsp_err, e.err);
            end
         end
         if (m_valid && o_req_ready) begin
            if (m_write) begin
               $display("wr  dut%0d addr=%0d data=%02h", sel, m_addr, m_wdata);
               if (int'(m_addr) < depth_of[sel]) model[sel][m_addr] = m_wdata;
            end else begin
               exp_t e;
               e.addr = int'(m_addr);
               e.err  = int'(m_addr) >= depth_of[sel];
               e.data = e.err ? 8'h00 : model[sel][m_addr];
               sb.push_back(e);
            end
         end
      end
   end

   // Holds the request until accepted; n reports how many cycles that took.
   task automatic issue(input bit wr, input int addr, input int data, output int n);
      n = 0;
      m_valid = 1'b1;
      m_write = wr;
      m_addr  = 8'(addr);
      m_wdata = 8'(data);
      do begin
         @(negedge clk);
         n++;
      end while (!o_req_ready && n < 50);
      if (!o_req_ready) chk("req_accept_timeout", o_req_ready, 1);
      @(posedge clk);
      #1;
      m_valid = 1'b0;
   endtask

   task automatic rd(input int addr);
      int n;
      issue(1'b0, addr, 0, n);
   endtask

   task automatic wr(input int addr, input int data);
      int n;
      issue(1'b1, addr, data, n);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic wait_init();
      int c0 = 0, c1 = 0;
      for (int cyc = 1; cyc <= 400 && (c0 == 0 || c1 == 0); cyc++) begin
         @(posedge clk);
         #1;
         if (!init_done0) chk("init_req_ready0", bus0.req_ready, 0);
         if (!init_done1) chk("init_req_ready1", bus1.req_ready, 0);
         if (init_done0 && c0 == 0) c0 = cyc;
         if (init_done1 && c1 == 0) c1 = cyc;
      end
      chk("init_cycles0", c0, 256);
      chk("init_cycles1", c1, 200);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      sel = 1'b0;
      m_valid = 1'b0;
      m_write = 1'b0;
      m_addr = 8'h00;
      m_wdata = 8'h00;
      m_rsp_ready = 1'b1;
      init_model();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp_valid", bus0.rsp_valid, 0);
      chk("rst_rsp_err", bus0.rsp_err, 0);
      chk("rst_rsp_rdata", bus0.rsp_rdata, 0);
      chk("rst_init_done0", init_done0, 0);
      chk("rst_init_done1", init_done1, 0);
      chk("rst_req_ready", bus0.req_ready, 0);
      rst = 1'b0;
      wait_init();

      // Square-table reads, including the wrap at 16 and the top word.
      rd(5);
      rd(16);
      rd(255);
      rd(0);
      drain();

      // Write followed immediately by a read of the same word.
      wr(3, 8'hA5);
      rd(3);
      drain();

      // Stalled response holds; release lets a new read in on the same cycle.
      m_rsp_ready = 1'b0;
      rd(7);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", o_rsp_valid, 1);
         chk("hold_rsp_rdata", o_rsp_rdata, model[0][7]);
         chk("hold_req_ready", o_req_ready, 0);
      end
      @(posedge clk);
      #1;
      m_rsp_ready = 1'b1;
      issue(1'b0, 9, 0, n);
      chk("hold_release_same_cycle", n, 1);
      drain();

      // Out-of-range read and write on the 200-word instance.
      sel = 1'b1;
      rd(250);
      wr(250, 8'h33);
      rd(50);
      rd(199);
      drain();
      chk("oor_model_50", model[1][50], 196);
      sel = 1'b0;

      // Reset with a response pending.
      m_rsp_ready = 1'b0;
      rd(10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_rsp_valid", bus0.rsp_valid, 0);
      chk("midrst_init_done", init_done0, 0);
      chk("midrst_req_ready", bus0.req_ready, 0);
      m_rsp_ready = 1'b1;
      rst = 1'b0;
      init_model();
      wait_init();
      chk("reinit_word3", 32'(model[0][3]), 9);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 255), $urandom_range(0, 255));
         else rd($urandom_range(0, 255));
      end
      rd(3);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
